sram_port_arbiter: RTL and testbench

- Shares one sky130 1RW SRAM port (32x1024, active-low csb/web, byte wmask) between two requesters.
  - Port 0 (P0): the TL-UL memory adapter (read/write).
  - Port 1 (P1): the UART program loader (write-mostly).
- Sits between the ICCM adapter/loader and the macro, replacing direct wiring.
- Provides round-robin arbitration, one-cycle response routing, out-of-range error responses, and a program-mode lock that drains P0 and gives P1 exclusive access.

---
 rtl/sram_arb_pkg.sv | 21 ++
 rtl/sram_arb_rr2.sv | 42 ++++
 rtl/sram_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        DRAIN  = 2'b01,
        PROG   = 2'b10
    } arb_state_e;

    localparam int NumPorts = 2;
    localparam int PortBus  = 0;
    localparam int PortProg = 1;

    function automatic logic [NumPorts-1:0] port_onehot(input logic idx);
        logic [NumPorts-1:0] oh;
        oh = 2'b00;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-requester round-robin picker; masked requesters are ignored and the
// pointer only moves when both unmasked requesters compete.
module sram_arb_rr2
    import sram_arb_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic [NumPorts-1:0] req_i,
    input  logic [NumPorts-1:0] mask_i,
    output logic [NumPorts-1:0] gnt_o
);

    logic                rr_ptr_r;
    logic [NumPorts-1:0] eff_s;

    // Grant selection from the unmasked requests.
    always_comb begin
        eff_s = req_i & ~mask_i;
        gnt_o = 2'b00;
        case (eff_s)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = port_onehot(rr_ptr_r);
            default: gnt_o = 2'b00;
        endcase
    end

    // Pointer flips to the loser after a contended grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_r <= 1'b0;
        end else if (clr_i) begin
            rr_ptr_r <= 1'b0;
        end else if (&eff_s) begin
            rr_ptr_r <= ~rr_ptr_r;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 1RW SRAM port between the bus adapter (P0) and the program loader (P1).
// Define SRAM_ARB_PERF_EN to add the contention counter (perf_clr_i / perf_conflict_o).
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AddrWidth = 12,
    parameter int MemAw     = 10,
    parameter int DataWidth = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 prog_mode_i,
    output logic                                 prog_lock_o,
    input  logic [NumPorts-1:0]                  req_i,
    input  logic [NumPorts-1:0]                  we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]   addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
    input  logic [NumPorts-1:0][DataWidth/8-1:0] wmask_i,
    output logic [NumPorts-1:0]                  gnt_o,
    output logic [NumPorts-1:0]                  rvalid_o,
    output logic [DataWidth-1:0]                 rdata_o,
    output logic                                 err_o,
    output logic                                 csb_o,
    output logic                                 web_o,
    output logic [DataWidth/8-1:0]               wmask_o,
    output logic [MemAw-1:0]                     addr_o,
    output logic [DataWidth-1:0]                 wdata_o,
    input  logic [DataWidth-1:0]                 rdata_i
`ifdef SRAM_ARB_PERF_EN
    ,
    input  logic                                 perf_clr_i,
    output logic [15:0]                          perf_conflict_o
`endif
);

    localparam int MaskWidth = DataWidth / 8;

    arb_state_e           state_r;
    arb_state_e           state_next_s;
    logic                 lock_s;
    logic                 rr_clr_s;
    logic [NumPorts-1:0]  mask_s;
    logic [NumPorts-1:0]  gnt_s;
    logic [NumPorts-1:0]  rvalid_r;
    logic                 win_s;
    logic                 any_s;
    logic                 in_range_s;
    logic                 access_s;
    logic                 err_r;
    logic                 rd_pend_r;
    logic                 prog_lock_r;
    logic [AddrWidth-1:0] addr_sel_s;

    // The lock follows prog_mode_i combinationally so P0 is blocked in the request cycle.
    assign lock_s   = prog_mode_i | (state_r != NORMAL);
    assign mask_s   = {1'b0, lock_s};
    assign rr_clr_s = (state_r == PROG) & ~prog_mode_i;

    sram_arb_rr2 u_rr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (rr_clr_s),
        .req_i  (req_i),
        .mask_i (mask_s),
        .gnt_o  (gnt_s)
    );

    // Winner selection and range decode.
    always_comb begin
        any_s      = |gnt_s;
        win_s      = gnt_s[PortProg];
        addr_sel_s = addr_i[win_s];
        in_range_s = (addr_sel_s[AddrWidth-1:MemAw] == {(AddrWidth-MemAw){1'b0}});
        access_s   = any_s & in_range_s;
    end

    // Grant and SRAM drive; reset forces the idle values without waiting for a clock.
    always_comb begin
        gnt_o   = gnt_s & {NumPorts{rst_ni}};
        csb_o   = 1'b1;
        web_o   = 1'b1;
        addr_o  = {MemAw{1'b0}};
        wdata_o = {DataWidth{1'b0}};
        wmask_o = {MaskWidth{1'b0}};
        if (access_s && rst_ni) begin
            csb_o   = 1'b0;
            web_o   = ~we_i[win_s];
            addr_o  = addr_sel_s[MemAw-1:0];
            wdata_o = wdata_i[win_s];
            wmask_o = wmask_i[win_s];
        end else begin
            csb_o   = 1'b1;
            web_o   = 1'b1;
        end
    end

    // Lock state machine next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            NORMAL: begin
                if (prog_mode_i) state_next_s = DRAIN;
                else             state_next_s = NORMAL;
            end
            DRAIN: begin
                if (!prog_mode_i)           state_next_s = NORMAL;
                else if (!rvalid_r[PortBus]) state_next_s = PROG;
                else                        state_next_s = DRAIN;
            end
            PROG: begin
                if (!prog_mode_i) state_next_s = NORMAL;
                else              state_next_s = PROG;
            end
            default: state_next_s = NORMAL;
        endcase
    end

    // State and one-cycle response pipeline; the ungated grant is safe here since reset dominates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= NORMAL;
            rvalid_r    <= 2'b00;
            err_r       <= 1'b0;
            rd_pend_r   <= 1'b0;
            prog_lock_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            rvalid_r    <= gnt_s;
            err_r       <= any_s & ~in_range_s;
            rd_pend_r   <= access_s & ~we_i[win_s];
            prog_lock_r <= (state_next_s == PROG);
        end
    end

    // Read data only passes through for an in-range read response.
    always_comb begin
        if (rd_pend_r) rdata_o = rdata_i;
        else           rdata_o = {DataWidth{1'b0}};
    end

    assign rvalid_o    = rvalid_r;
    assign err_o       = err_r;
    assign prog_lock_o = prog_lock_r;

`ifdef SRAM_ARB_PERF_EN
    logic [15:0] perf_cnt_r;

    // Saturating count of cycles where both ports request (one is always denied).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cnt_r <= 16'd0;
        end else if (perf_clr_i) begin
            perf_cnt_r <= 16'd0;
        end else if ((&req_i) && (perf_cnt_r != 16'hFFFF)) begin
            perf_cnt_r <= perf_cnt_r + 16'd1;
        end else begin
            perf_cnt_r <= perf_cnt_r;
        end
    end

    assign perf_conflict_o = perf_cnt_r;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized self-checking bench for sram_port_arbiter with an SRAM model and a
// transaction-level reference of grants, lock state and memory contents.
module tb_sram_port_arbiter;

    localparam int AW = 12;
    localparam int MW = 10;
    localparam int DW = 32;
    localparam int BW = 4;

    logic                 clk = 1'b0;
    logic                 rst_ni;
    logic                 prog_mode_i;
    logic                 prog_lock_o;
    logic [1:0]           req_i;
    logic [1:0]           we_i;
    logic [1:0][AW-1:0]   addr_i;
    logic [1:0][DW-1:0]   wdata_i;
    logic [1:0][BW-1:0]   wmask_i;
    logic [1:0]           gnt_o;
    logic [1:0]           rvalid_o;
    logic [DW-1:0]        rdata_o;
    logic                 err_o;
    logic                 csb_o;
    logic                 web_o;
    logic [BW-1:0]        wmask_o;
    logic [MW-1:0]        addr_o;
    logic [DW-1:0]        wdata_o;
    logic [DW-1:0]        rdata_i;
`ifdef SRAM_ARB_PERF_EN
    logic                 perf_clr_i;
    logic [15:0]          perf_conflict_o;
`endif

    int total = 0;
    int bad   = 0;

    // Requester intent
    logic [1:0]    b_req;
    logic [1:0]    b_we;
    logic [AW-1:0] b_addr  [2];
    logic [DW-1:0] b_wdata [2];
    logic [BW-1:0] b_wmask [2];
    logic          b_prog;

    // Reference model: mode 0=normal 1=draining 2=locked
    int            mdl_mode;
    int            mdl_turn;
    int            mdl_rv;
    bit            mdl_err;
    logic [DW-1:0] mdl_rdata;
    int            mdl_perf;
    bit [DW-1:0]   ref_mem  [1024];
    bit [DW-1:0]   sram_mem [1024];

    logic [1:0]    last_gnt;
    logic [1:0]    last_rv;
    logic [DW-1:0] last_rdata;
    logic          last_err;

    sram_port_arbiter dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .prog_mode_i (prog_mode_i),
        .prog_lock_o (prog_lock_o),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .wmask_i     (wmask_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .csb_o       (csb_o),
        .web_o       (web_o),
        .wmask_o     (wmask_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .rdata_i     (rdata_i)
`ifdef SRAM_ARB_PERF_EN
        ,
        .perf_clr_i      (perf_clr_i),
        .perf_conflict_o (perf_conflict_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [BW-1:0] m);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < BW; b++) begin
            if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // SRAM macro model: registered read data, masked writes.
    always @(posedge clk) begin
        if (!csb_o) begin
            if (!web_o) sram_mem[addr_o] <= merge_bytes(sram_mem[addr_o], wdata_o, wmask_o);
            else        rdata_i <= sram_mem[addr_o];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        req_i       = b_req;
        we_i        = b_we;
        prog_mode_i = b_prog;
        for (int p = 0; p < 2; p++) begin
            addr_i[p]  = b_addr[p];
            wdata_i[p] = b_wdata[p];
            wmask_i[p] = b_wmask[p];
        end
    endtask

    task automatic issue(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] m);
        b_req[p]   = 1'b1;
        b_we[p]    = we;
        b_addr[p]  = a;
        b_wdata[p] = d;
        b_wmask[p] = m;
    endtask

    task automatic random_issue(input int p);
        int r;
        logic [AW-1:0] a;
        r = $urandom_range(0, 15);
        if (r == 0)      a = 12'h400 + AW'($urandom_range(0, 1023));
        else if (r == 1) a = 12'h3FF;
        else if (r == 2) a = 12'hFFF;
        else             a = AW'($urandom_range(0, 31));
        issue(p, 1'($urandom_range(0, 1)), a, $urandom, BW'($urandom_range(0, 15)));
    endtask

    // One clock: drive at negedge, check grant/SRAM drive, advance model, check response.
    task automatic cycle();
        int         w;
        int         resp_before;
        bit         e0;
        bit         e1;
        bit         inr;
        logic [1:0] exp_gnt;
        logic [1:0] exp_rv;
        drive_inputs();
        #1;
        e0 = b_req[0] && !b_prog && (mdl_mode == 0);
        e1 = b_req[1];
        w  = -1;
        if (e0 && e1) w = mdl_turn;
        else if (e0)  w = 0;
        else if (e1)  w = 1;
        exp_gnt = 2'b00;
        inr     = 1'b0;
        if (w >= 0) begin
            exp_gnt[w] = 1'b1;
            inr = (b_addr[w] < 12'h400);
        end
        last_gnt = gnt_o;
        check_eq("gnt", 32'(gnt_o), 32'(exp_gnt));
        check_eq("csb", 32'(csb_o), 32'(!inr));
        if (inr) begin
            check_eq("web", 32'(web_o), 32'(!b_we[w]));
            check_eq("addr_o", 32'(addr_o), 32'(b_addr[w][MW-1:0]));
            if (b_we[w]) begin
                check_eq("wdata_o", wdata_o, b_wdata[w]);
                check_eq("wmask_o", 32'(wmask_o), 32'(b_wmask[w]));
            end
        end else begin
            check_eq("web_idle", 32'(web_o), 32'd1);
        end
        @(posedge clk);
        resp_before = mdl_rv;
        case (mdl_mode)
            0: if (b_prog) mdl_mode = 1;
            1: begin
                if (!b_prog)               mdl_mode = 0;
                else if (resp_before != 0) mdl_mode = 2;
            end
            default: begin
                if (!b_prog) begin
                    mdl_mode = 0;
                    mdl_turn = 0;
                end
            end
        endcase
        if (e0 && e1) mdl_turn = 1 - w;
        if (b_req == 2'b11 && mdl_perf < 65535) mdl_perf++;
        mdl_rv    = w;
        mdl_err   = (w >= 0) && !inr;
        mdl_rdata = '0;
        if (inr) begin
            if (b_we[w]) ref_mem[b_addr[w][MW-1:0]] = merge_bytes(ref_mem[b_addr[w][MW-1:0]],
                                                                  b_wdata[w], b_wmask[w]);
            else         mdl_rdata = ref_mem[b_addr[w][MW-1:0]];
        end
        if (w >= 0) b_req[w] = 1'b0;
        #1;
        exp_rv = 2'b00;
        if (mdl_rv >= 0) exp_rv[mdl_rv] = 1'b1;
        last_rv    = rvalid_o;
        last_rdata = rdata_o;
        last_err   = err_o;
        check_eq("rvalid", 32'(rvalid_o), 32'(exp_rv));
        if (mdl_rv >= 0) begin
            check_eq("err", 32'(err_o), 32'(mdl_err));
            check_eq("rdata", rdata_o, mdl_rdata);
        end
        check_eq("prog_lock", 32'(prog_lock_o), 32'(mdl_mode == 2));
`ifdef SRAM_ARB_PERF_EN
        check_eq("perf", 32'(perf_conflict_o), 32'(mdl_perf));
`endif
        @(negedge clk);
    endtask

    task automatic run_until_idle();
        int n;
        n = 0;
        while (b_req != 2'b00 && n < 20) begin
            cycle();
            n++;
        end
        check_eq("idle_timeout", 32'(b_req), 32'd0);
    endtask

    // Asserts reset with whatever inputs are driven and checks the idle outputs immediately.
    task automatic apply_reset();
        drive_inputs();
        rst_ni = 1'b0;
        #1;
        check_eq("rst_rvalid", 32'(rvalid_o), 32'd0);
        check_eq("rst_err", 32'(err_o), 32'd0);
        check_eq("rst_lock", 32'(prog_lock_o), 32'd0);
        check_eq("rst_csb", 32'(csb_o), 32'd1);
        check_eq("rst_web", 32'(web_o), 32'd1);
        check_eq("rst_gnt", 32'(gnt_o), 32'd0);
        check_eq("rst_addr", 32'(addr_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni   = 1'b1;
        b_req    = 2'b00;
        b_prog   = 1'b0;
        mdl_mode = 0;
        mdl_turn = 0;
        mdl_rv   = -1;
        mdl_perf = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b1;
`ifdef SRAM_ARB_PERF_EN
        perf_clr_i = 1'b0;
`endif
        b_prog = 1'b0;
        b_we   = 2'b00;
        for (int p = 0; p < 2; p++) begin
            b_addr[p]  = '0;
            b_wdata[p] = '0;
            b_wmask[p] = '0;
        end
        b_req = 2'b11;
        drive_inputs();
        #2;
        apply_reset();

        // Single-port write then read
        issue(0, 1'b1, 12'h005, 32'hDEADBEEF, 4'hF);
        run_until_idle();
        issue(0, 1'b0, 12'h005, 32'h0, 4'h0);
        run_until_idle();
        check_eq("p0_read_data", last_rdata, 32'hDEADBEEF);
        check_eq("p0_read_rv", 32'(last_rv), 32'd1);

        // Byte mask merge
        issue(1, 1'b1, 12'h010, 32'h11223344, 4'hF);
        run_until_idle();
        issue(1, 1'b1, 12'h010, 32'hAABBCCDD, 4'b0101);
        run_until_idle();
        issue(1, 1'b0, 12'h010, 32'h0, 4'h0);
        run_until_idle();
        check_eq("mask_merge", last_rdata, 32'h11BB33DD);

        // Out-of-range write must not alias onto word 0
        issue(0, 1'b1, 12'h000, 32'hCAFEF00D, 4'hF);
        run_until_idle();
        issue(1, 1'b1, 12'h400, 32'h55555555, 4'hF);
        run_until_idle();
        check_eq("oor_err", 32'(last_err), 32'd1);
        check_eq("oor_rv", 32'(last_rv), 32'd2);
        check_eq("oor_untouched", sram_mem[0], 32'hCAFEF00D);

        // Reset in the cycle after a read grant
        issue(0, 1'b0, 12'h005, 32'h0, 4'h0);
        cycle();
        b_req = 2'b11;
        apply_reset();

        // Contention right after reset: P0 first, then alternate
        for (int i = 0; i < 6; i++) begin
            if (!b_req[0]) issue(0, 1'b0, AW'(i), 32'h0, 4'h0);
            if (!b_req[1]) issue(1, 1'b0, AW'(i + 8), 32'h0, 4'h0);
            cycle();
            check_eq("cont_order", 32'(last_gnt), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        run_until_idle();

        // Program lock
        for (int i = 0; i < 4; i++) begin
            if (!b_req[0]) issue(0, 1'b0, AW'($urandom_range(0, 31)), 32'h0, 4'h0);
            cycle();
        end
        b_prog = 1'b1;
        if (!b_req[0]) issue(0, 1'b0, 12'h003, 32'h0, 4'h0);
        issue(1, 1'b1, 12'h020, $urandom, 4'hF);
        cycle();
        check_eq("lock_p0_blocked", 32'(last_gnt), 32'd2);
        for (int i = 0; i < 3; i++) begin
            issue(1, 1'b1, AW'(12'h021 + i), $urandom, 4'hF);
            cycle();
            if (i == 0) check_eq("lock_2cyc", 32'(prog_lock_o), 32'd1);
            check_eq("lock_p1_b2b", 32'(last_gnt), 32'd2);
        end
        b_prog = 1'b0;
        issue(1, 1'b1, 12'h030, $urandom, 4'hF);
        cycle();
        issue(1, 1'b1, 12'h031, $urandom, 4'hF);
        cycle();
        check_eq("unlock_p0", 32'(last_gnt), 32'd1);
        run_until_idle();

        // Randomized traffic with occasional program-mode toggles
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 39) == 0) b_prog = ~b_prog;
            for (int p = 0; p < 2; p++) begin
                if (!b_req[p] && $urandom_range(0, 9) < 7) random_issue(p);
            end
            cycle();
        end
        b_prog = 1'b0;
        run_until_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
